// File: rtl/site_mutator.sv
// site_mutator: per-site nucleotide mutator. Each accepted beat draws a
// pseudo-random number from a 16-bit Galois LFSR and samples the child
// nucleotide from the parent's row of the transition matrix. Once every site
// of the alignment word has been written, the child word is offered downstream.
module site_mutator #(
    parameter int          N_SITES   = 8,
    parameter int          PW        = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$clog2(N_SITES)-1:0] pos,
    input  logic [4*N_SITES-1:0]       nucl_alig,
    input  logic [16*PW-1:0]           matrix_P,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4*N_SITES-1:0]       child_alig,
    output logic                       err
);

    localparam int          POS_W = $clog2(N_SITES);
    localparam int          CW    = PW + 2;
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] POLY  = 16'hB400;

    typedef enum logic [2:0] {IDLE, DRAW, SELECT, WRITE, FULL} state_t;

    state_t               state_reg;
    logic [POS_W-1:0]     pos_reg;
    logic [3:0]           parent_reg;
    logic [3*PW-1:0]      row_reg;      // P3 never influences the draw, so only three entries are kept
    logic [15:0]          lfsr_reg;
    logic [PW-1:0]        r_reg;
    logic [3:0]           child_reg;
    logic [4*N_SITES-1:0] buf_reg;
    logic [N_SITES-1:0]   mask_reg;
    logic                 err_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;

    logic [3:0]           parent_in;
    logic [1:0]           row_idx;
    logic [3*PW-1:0]      row_in;
    logic                 parent_valid;
    logic [15:0]          lfsr_step;
    logic [CW-1:0]        cum0, cum1, cum2, r_ext;
    logic [3:0]           child_sel;
    logic [N_SITES-1:0]   pos_onehot;
    logic [N_SITES-1:0]   mask_set;

    // Slot decoder for the site currently being written.
    generate
        for (genvar gi = 0; gi < N_SITES; gi++) begin : g_pos_dec
            assign pos_onehot[gi] = (pos_reg == POS_W'(gi));
        end
    endgenerate

    assign mask_set = mask_reg | pos_onehot;

    // Pick the parent nibble at the incoming position and its matrix row.
    always_comb begin
        parent_in = nucl_alig[pos*4 +: 4];
        row_idx   = 2'd0;
        case (parent_in)
            4'b0001: row_idx = 2'd0;
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        row_in = matrix_P[row_idx*4*PW +: 3*PW];
    end

    // Next LFSR state: Galois form, shifting right.
    always_comb begin
        lfsr_step = lfsr_reg >> 1;
        if (lfsr_reg[0]) begin
            lfsr_step = (lfsr_reg >> 1) ^ POLY;
        end
    end

    // Inverse-CDF sampling; any mass left beyond cum2 falls to T.
    always_comb begin
        parent_valid = 1'b0;
        case (parent_reg)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: parent_valid = 1'b1;
            default:                            parent_valid = 1'b0;
        endcase
        cum0  = {2'b00, row_reg[PW-1:0]};
        cum1  = cum0 + {2'b00, row_reg[2*PW-1:PW]};
        cum2  = cum1 + {2'b00, row_reg[3*PW-1:2*PW]};
        r_ext = {2'b00, r_reg};
        if (r_ext < cum0) begin
            child_sel = 4'b0001;
        end else if (r_ext < cum1) begin
            child_sel = 4'b0010;
        end else if (r_ext < cum2) begin
            child_sel = 4'b0100;
        end else begin
            child_sel = 4'b1000;
        end
        // A corrupt parent passes through untouched.
        if (!parent_valid) begin
            child_sel = parent_reg;
        end
    end

    // Main control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            pos_reg       <= '0;
            parent_reg    <= '0;
            row_reg       <= '0;
            lfsr_reg      <= SEED;
            r_reg         <= '0;
            child_reg     <= '0;
            buf_reg       <= '0;
            mask_reg      <= '0;
            err_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        pos_reg      <= pos;
                        parent_reg   <= parent_in;
                        row_reg      <= row_in;
                        in_ready_reg <= 1'b0;
                        state_reg    <= DRAW;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                DRAW: begin
                    lfsr_reg  <= lfsr_step;
                    r_reg     <= lfsr_step[PW-1:0];
                    state_reg <= SELECT;
                end
                SELECT: begin
                    child_reg <= child_sel;
                    if (!parent_valid) begin
                        err_reg <= 1'b1;
                    end
                    state_reg <= WRITE;
                end
                WRITE: begin
                    buf_reg[pos_reg*4 +: 4] <= child_reg;
                    mask_reg                <= mask_set;
                    if (&mask_set) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= FULL;
                    end else begin
                        in_ready_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        mask_reg      <= '0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign child_alig = buf_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_site_mutator.sv
// Directed testbench for site_mutator: each scenario task drives beats and
// checks the assembled child word against a small LFSR sampling model.
module tb_site_mutator;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   pos = 3'd0;
    logic [31:0]  nucl_alig = 32'h0;
    logic [159:0] matrix_P = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  child_alig;
    logic         err;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [15:0]  lfsr_m = 16'hACE1;
    logic [31:0]  exp_buf = 32'h0;
    logic [31:0]  rand_word = 32'h0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    site_mutator dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pos        (pos),
        .nucl_alig  (nucl_alig),
        .matrix_P   (matrix_P),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .child_alig (child_alig),
        .err        (err)
    );

    function automatic logic [159:0] mat_of(input int pv);
        logic [159:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[i*10 +: 10] = pv[9:0];
        return m;
    endfunction

    // Reference: one LFSR step per beat, thresholds pv, 2pv, 3pv for a uniform matrix.
    task automatic model_beat(input int p, input logic [31:0] nucl, input int pv);
        logic [3:0] par;
        logic [3:0] ch;
        int r;
        par = nucl[p*4 +: 4];
        lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
        r = int'(lfsr_m[9:0]);
        if (par == 4'h1 || par == 4'h2 || par == 4'h4 || par == 4'h8) begin
            if (r < pv) ch = 4'h1;
            else if (r < 2*pv) ch = 4'h2;
            else if (r < 3*pv) ch = 4'h4;
            else ch = 4'h8;
        end else begin
            ch = par;
        end
        exp_buf[p*4 +: 4] = ch;
    endtask

    task automatic send_beat(input int p, input logic [31:0] nucl, input int pv, output int acc);
        int n;
        n = 0;
        acc = 0;
        @(negedge clk);
        pos = 3'(p);
        nucl_alig = nucl;
        matrix_P = mat_of(pv);
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept pos=%0d in_ready=%b required 1", p, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Inputs are only sampled on the accepting edge; scramble them afterwards.
        nucl_alig = ~nucl;
        matrix_P = ~matrix_P;
        acc = cyc;
        model_beat(p, nucl, pv);
        $display("beat pos=%0d parent=%h expected_child=%h", p, nucl[p*4 +: 4], exp_buf[p*4 +: 4]);
    endtask

    task automatic wait_out(output int t);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout out_valid=%b required 1", out_valid);
        end
        t = cyc;
    endtask

    task automatic do_transfer();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL xfer_out_valid got=%b required 0", out_valid);
        end
        $display("transfer child=%h", child_alig);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        lfsr_m = 16'hACE1;
        exp_buf = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b required 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b required 0", out_valid); end
        checks++;
        if (child_alig !== 32'h0) begin errors++; $display("FAIL rst_child got=%h required 0", child_alig); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b required 0", err); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got=%b required 1", in_ready); end
        $display("reset done in_ready=%b", in_ready);
    endtask

    task automatic test_zero_matrix();
        int t_first, t_acc, t_ov, lat;
        t_first = 0;
        for (int p = 0; p < 8; p++) begin
            send_beat(p, 32'h1248_1248, 0, t_acc);
            if (p == 0) t_first = t_acc;
        end
        wait_out(t_ov);
        lat = t_ov + 1 - t_first;
        checks++;
        if (child_alig !== 32'h8888_8888) begin errors++; $display("FAIL zero_child got=%h required 88888888", child_alig); end
        checks++;
        if (child_alig !== exp_buf) begin errors++; $display("FAIL zero_child_model got=%h required %h", child_alig, exp_buf); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL zero_err got=%b required 0", err); end
        checks++;
        if (lat != 32) begin errors++; $display("FAIL zero_latency got=%0d required 32", lat); end
        $display("zero_matrix child=%h latency=%0d", child_alig, lat);
        do_transfer();
    endtask

    task automatic test_random_sampling();
        int t;
        apply_reset();
        for (int p = 0; p < 8; p++) send_beat(p, 32'h1111_1111, 256, t);
        wait_out(t);
        for (int p = 0; p < 8; p++) begin
            checks++;
            if (child_alig[p*4 +: 4] !== exp_buf[p*4 +: 4]) begin
                errors++;
                $display("FAIL rand_slot%0d got=%h required %h", p, child_alig[p*4 +: 4], exp_buf[p*4 +: 4]);
            end
        end
        rand_word = exp_buf;
        $display("random child=%h expected=%h", child_alig, exp_buf);
        do_transfer();
    endtask

    task automatic test_invalid_parent();
        int t;
        for (int p = 0; p < 8; p++) send_beat(p, 32'h1131_0111, 256, t);
        wait_out(t);
        checks++;
        if (child_alig[15:12] !== 4'b0000) begin errors++; $display("FAIL inv_slot3 got=%b required 0000", child_alig[15:12]); end
        checks++;
        if (child_alig[23:20] !== 4'b0011) begin errors++; $display("FAIL inv_slot5 got=%b required 0011", child_alig[23:20]); end
        checks++;
        if (child_alig !== exp_buf) begin errors++; $display("FAIL inv_child_model got=%h required %h", child_alig, exp_buf); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL inv_err got=%b required 1", err); end
        $display("invalid_parent child=%h err=%b", child_alig, err);
        do_transfer();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL inv_err_sticky got=%b required 1", err); end
    endtask

    task automatic test_backpressure();
        int t;
        for (int p = 0; p < 8; p++) send_beat(p, 32'h8421_1248, 256, t);
        wait_out(t);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            pos = 3'(k);
            nucl_alig = 32'h4444_4444;
            matrix_P = mat_of(700);
            @(posedge clk);
            #1;
            checks++;
            if (child_alig !== exp_buf || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d child=%h ov=%b ir=%b required child=%h ov=1 ir=0",
                         k, child_alig, out_valid, in_ready, exp_buf);
            end
        end
        in_valid = 1'b0;
        $display("backpressure held child=%h", child_alig);
        do_transfer();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got=%b required 1", in_ready); end
    endtask

    task automatic test_duplicate_pos();
        int t;
        int seq [9] = '{2, 2, 0, 1, 3, 4, 5, 6, 7};
        for (int i = 0; i < 8; i++) send_beat(seq[i], 32'h1248_4821, 300, t);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL dup_early_out_valid got=%b required 0", out_valid); end
        send_beat(seq[8], 32'h1248_4821, 300, t);
        wait_out(t);
        checks++;
        if (child_alig !== exp_buf) begin errors++; $display("FAIL dup_child got=%h required %h", child_alig, exp_buf); end
        $display("duplicate_pos child=%h expected=%h", child_alig, exp_buf);
        do_transfer();
    endtask

    task automatic test_reset_mid();
        int t;
        for (int p = 0; p < 6; p++) send_beat(p, 32'h1111_1111, 256, t);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || child_alig !== 32'h0 || err !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs ov=%b child=%h err=%b ir=%b required all 0",
                     out_valid, child_alig, err, in_ready);
        end
        lfsr_m = 16'hACE1;
        exp_buf = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got=%b required 1", in_ready); end
        for (int p = 0; p < 8; p++) send_beat(p, 32'h1111_1111, 256, t);
        wait_out(t);
        checks++;
        if (child_alig !== rand_word) begin errors++; $display("FAIL mid_replay got=%h required %h", child_alig, rand_word); end
        checks++;
        if (child_alig !== exp_buf) begin errors++; $display("FAIL mid_replay_model got=%h required %h", child_alig, exp_buf); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL mid_err got=%b required 0", err); end
        $display("reset_mid replay child=%h", child_alig);
        do_transfer();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_matrix();
        test_random_sampling();
        test_invalid_parent();
        test_backpressure();
        test_duplicate_pos();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
